// File: rtl/alu_pkg.sv
// Shared ALU-side types: NZCV flag vector, flag bit positions and branch condition codes.
package alu_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational branch-condition evaluator: (NZCV, condition code) -> taken.
module cond_eval
  import alu_pkg::*;
(
  input  nzcv_t flags_i,
  input  cond_e cond_i,
  output logic  taken_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      EQ: taken_o = z;
      NE: taken_o = ~z;
      CS: taken_o = c;
      CC: taken_o = ~c;
      MI: taken_o = n;
      PL: taken_o = ~n;
      VS: taken_o = v;
      VC: taken_o = ~v;
      HI: taken_o = c & ~z;
      LS: taken_o = ~c | z;
      GE: taken_o = (n == v);
      LT: taken_o = (n != v);
      GT: taken_o = ~z & (n == v);
      LE: taken_o = z | (n != v);
      AL: taken_o = 1'b1;
      NV: taken_o = 1'b0;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flags_cond_unit.sv
// Architectural NZCV register with masked update and shadow copy, plus a
// valid/ready branch-condition evaluator with a one-entry result register.
module flags_cond_unit
  import alu_pkg::*;
#(
  parameter bit FORWARD    = 1'b1,
  parameter bit BORROW_INV = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] FlagsNZCV,
  input  logic       flags_we,
  input  logic [3:0] flags_mask,
  output logic       AddSubCBin,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       taken_valid,
  output logic       taken,
  input  logic       taken_ready,
  input  logic       save_flags,
  input  logic       restore_flags,
  output logic [3:0] flags_q,
  output logic [3:0] shadow_q
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e state_q, state_d;
  nzcv_t  flags_d, shadow_d, eval_flags;
  logic   taken_q, taken_d, eval_taken, accept;

  // Restore wins over a same-cycle write; save always captures the pre-edge value,
  // so save+restore together swaps the two registers.
  always_comb begin
    flags_d = flags_q;
    if (restore_flags) begin
      flags_d = shadow_q;
    end else if (flags_we) begin
      flags_d = (flags_q & ~flags_mask) | (FlagsNZCV & flags_mask);
    end
  end

  assign shadow_d   = save_flags ? flags_q : shadow_q;
  assign AddSubCBin = flags_q[FLAG_C] ^ BORROW_INV;

  assign eval_flags = FORWARD ? flags_d : flags_q;

  cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .cond_i  (cond_e'(cond_code)),
    .taken_o (eval_taken)
  );

  always_comb begin
    cond_ready  = 1'b1;
    taken_valid = 1'b0;
    state_d     = state_q;
    if (state_q == RESP) begin
      taken_valid = 1'b1;
      cond_ready  = taken_ready;
    end
    accept  = cond_valid & cond_ready;
    taken_d = accept ? eval_taken : taken_q;
    if (accept) begin
      state_d = RESP;
    end else if ((state_q == RESP) && taken_ready) begin
      state_d = IDLE;
    end
  end

  assign taken = taken_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q  <= '0;
      shadow_q <= '0;
      state_q  <= IDLE;
      taken_q  <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      state_q  <= state_d;
      taken_q  <= taken_d;
    end
  end

endmodule

// File: tb/tb_flags_cond_unit.sv
// Randomized and directed checks of flags_cond_unit against a behavioural model.
module tb_flags_cond_unit;

  localparam bit FWD = 1'b1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] FlagsNZCV = '0;
  logic       flags_we = 1'b0;
  logic [3:0] flags_mask = '0;
  logic       AddSubCBin;
  logic       cond_valid = 1'b0;
  logic [3:0] cond_code = '0;
  logic       cond_ready;
  logic       taken_valid;
  logic       taken;
  logic       taken_ready = 1'b0;
  logic       save_flags = 1'b0;
  logic       restore_flags = 1'b0;
  logic [3:0] flags_q;
  logic [3:0] shadow_q;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_flags, m_shadow;
  bit         m_res[$];

  flags_cond_unit #(.FORWARD(FWD), .BORROW_INV(1'b0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .FlagsNZCV     (FlagsNZCV),
    .flags_we      (flags_we),
    .flags_mask    (flags_mask),
    .AddSubCBin    (AddSubCBin),
    .cond_valid    (cond_valid),
    .cond_code     (cond_code),
    .cond_ready    (cond_ready),
    .taken_valid   (taken_valid),
    .taken         (taken),
    .taken_ready   (taken_ready),
    .save_flags    (save_flags),
    .restore_flags (restore_flags),
    .flags_q       (flags_q),
    .shadow_q      (shadow_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference condition: interpret flags as a signed/unsigned compare outcome.
  function automatic bit ref_cond(input int code, input logic [3:0] f);
    bit n, z, c, v, signed_ge, unsigned_hi;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    signed_ge   = (n == v);
    unsigned_hi = c && !z;
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return unsigned_hi;
      9:  return !unsigned_hi;
      10: return signed_ge;
      11: return !signed_ge;
      12: return signed_ge && !z;
      13: return !(signed_ge && !z);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] f, input bit we, input logic [3:0] m,
                       input bit cv, input logic [3:0] code, input bit tr,
                       input bit sv, input bit rs);
    FlagsNZCV = f; flags_we = we; flags_mask = m;
    cond_valid = cv; cond_code = code; taken_ready = tr;
    save_flags = sv; restore_flags = rs;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit ready, acc;
    logic [3:0] nf;
    #1;
    ready = (m_res.size() == 0) || taken_ready;
    acc   = cond_valid && ready;
    chk("cond_ready", {3'b0, cond_ready}, {3'b0, ready});
    chk("cbin", {3'b0, AddSubCBin}, {3'b0, m_flags[1]});
    nf = m_flags;
    if (restore_flags) nf = m_shadow;
    else if (flags_we)
      for (int i = 0; i < 4; i++) if (flags_mask[i]) nf[i] = FlagsNZCV[i];
    if (m_res.size() != 0 && taken_ready) void'(m_res.pop_front());
    if (acc) m_res.push_back(ref_cond(int'(cond_code), FWD ? nf : m_flags));
    if (save_flags) m_shadow = m_flags;
    m_flags = nf;
    @(posedge clk);
    #1;
    chk("flags_q", flags_q, m_flags);
    chk("shadow_q", shadow_q, m_shadow);
    chk("taken_valid", {3'b0, taken_valid}, {3'b0, m_res.size() != 0});
    if (m_res.size() != 0) chk("taken", {3'b0, taken}, {3'b0, m_res[0]});
  endtask

  task automatic do_reset();
    drive(4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    m_flags = '0; m_shadow = '0; m_res.delete();
    chk("rst_taken_valid", {3'b0, taken_valid}, 4'h0);
    chk("rst_taken", {3'b0, taken}, 4'h0);
    chk("rst_flags", flags_q, 4'h0);
    chk("rst_shadow", shadow_q, 4'h0);
    chk("rst_cond_ready", {3'b0, cond_ready}, 4'h1);
    chk("rst_cbin", {3'b0, AddSubCBin}, 4'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Masked write
    drive(4'b1111, 1, 4'b0110, 0, 4'h0, 0, 0, 0); cycle();
    chk("mask_w1", flags_q, 4'b0110);
    chk("mask_cbin", {3'b0, AddSubCBin}, 4'h1);
    drive(4'b0000, 1, 4'b1001, 0, 4'h0, 0, 0, 0); cycle();
    chk("mask_w2", flags_q, 4'b0110);
    $display("txn masked_write flags=%b", flags_q);

    // Forwarding: write Z and evaluate EQ in the same cycle
    do_reset();
    drive(4'b0100, 1, 4'b1111, 1, 4'd0, 0, 0, 0); cycle();
    chk("fwd_taken", {3'b0, taken}, {3'b0, FWD});
    $display("txn forward_eq taken=%b", taken);

    // Signed compares
    drive(4'b1001, 1, 4'b1111, 1, 4'd10, 1, 0, 0); cycle();
    chk("ge", {3'b0, taken}, 4'h1);
    drive(4'h0, 0, 4'h0, 1, 4'd11, 1, 0, 0); cycle();
    chk("lt", {3'b0, taken}, 4'h0);
    drive(4'h0, 0, 4'h0, 1, 4'd12, 1, 0, 0); cycle();
    chk("gt", {3'b0, taken}, 4'h1);
    drive(4'b1100, 1, 4'b1111, 1, 4'd13, 1, 0, 0); cycle();
    chk("le", {3'b0, taken}, 4'h1);
    $display("txn signed_compare flags=%b", flags_q);

    // Backpressure
    do_reset();
    drive(4'h0, 0, 4'h0, 1, 4'd1, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1, 4'b1111, 0, 4'h0, 0, 0, 0); cycle();
      chk("bp_taken", {3'b0, taken}, 4'h1);
      chk("bp_ready", {3'b0, cond_ready}, 4'h0);
    end
    drive(4'h0, 0, 4'h0, 1, 4'd15, 1, 0, 0); cycle();
    chk("bp_nv_taken", {3'b0, taken}, 4'h0);
    chk("bp_nv_valid", {3'b0, taken_valid}, 4'h1);
    $display("txn backpressure taken=%b valid=%b", taken, taken_valid);

    // Shadow save / swap / reset during RESP
    do_reset();
    drive(4'b1010, 1, 4'b1111, 0, 4'h0, 0, 0, 0); cycle();
    drive(4'h0, 0, 4'h0, 0, 4'h0, 0, 1, 0); cycle();
    chk("save", shadow_q, 4'b1010);
    drive(4'b0101, 1, 4'b1111, 0, 4'h0, 0, 0, 0); cycle();
    drive(4'b1111, 1, 4'b1111, 0, 4'h0, 0, 1, 1); cycle();
    chk("swap_flags", flags_q, 4'b1010);
    chk("swap_shadow", shadow_q, 4'b0101);
    drive(4'h0, 0, 4'h0, 1, 4'd14, 0, 0, 0); cycle();
    $display("txn shadow flags=%b shadow=%b", flags_q, shadow_q);
    do_reset();

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      drive(4'($urandom), ($urandom_range(0, 2) != 0), 4'($urandom),
            ($urandom_range(0, 2) != 0), 4'($urandom), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      cycle();
      if (t % 500 == 499) $display("txn random_batch t=%0d flags=%b", t, flags_q);
      if (t == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
